// File: rtl/alu_writeback_pkg.sv
// ALU operation encoding plus the writeback-stage types and result classifier.
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_MSB_POS
`define PROC_FLAGS_MSB_POS 1
`endif

package pkg_alu;
  localparam int ALU_INOUT_WIDTH    = `ALU_INOUT_WIDTH;
  localparam int PROC_FLAGS_MSB_POS = `PROC_FLAGS_MSB_POS;
  localparam int PROC_FLAGS_WIDTH   = PROC_FLAGS_MSB_POS + 1;

  // Encodings 11..15 are left unassigned on purpose.
  typedef enum logic [3:0] {
    alu_op_add  = 4'd0,
    alu_op_sub  = 4'd1,
    alu_op_and  = 4'd2,
    alu_op_or   = 4'd3,
    alu_op_xor  = 4'd4,
    alu_op_lsl  = 4'd5,
    alu_op_lsr  = 4'd6,
    alu_op_inc  = 4'd7,
    alu_op_invp = 4'd8,
    alu_op_negp = 4'd9,
    alu_op_cmp  = 4'd10
  } alu_oper;
endpackage

package pkg_alu_wb;
  import pkg_alu::*;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WR_HI = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_PAIR   = 2'd2,
    CLS_FLAGS  = 2'd3
  } wb_class_t;

  function automatic wb_class_t get_alu_wb_class(input alu_oper oper);
    wb_class_t cls;
    case (oper)
      alu_op_add, alu_op_sub, alu_op_and, alu_op_or,
      alu_op_xor, alu_op_lsl, alu_op_lsr, alu_op_inc: cls = CLS_SINGLE;
      alu_op_invp, alu_op_negp:                       cls = CLS_PAIR;
      alu_op_cmp:                                     cls = CLS_FLAGS;
      default:                                        cls = CLS_NONE;
    endcase
    return cls;
  endfunction
endpackage

// File: rtl/alu_writeback_proc_flags_reg.sv
// Architectural flags register with load enable and synchronous reset.
module proc_flags_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/alu_writeback.sv
// ALU result writeback: one register write per single result, two (rd, rd+1) per pair result.
module alu_writeback
  import pkg_alu::*;
  import pkg_alu_wb::*;
#(
  parameter int REG_IDX_WIDTH = 4,
  parameter int DATA_WIDTH    = ALU_INOUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  alu_oper                     in_oper,
  input  logic [REG_IDX_WIDTH-1:0]    in_rd,
  input  logic [DATA_WIDTH-1:0]       in_out_lo,
  input  logic [DATA_WIDTH-1:0]       in_out_hi,
  input  logic [PROC_FLAGS_WIDTH-1:0] in_flags,
  output logic                        rf_we,
  output logic [REG_IDX_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  output logic [PROC_FLAGS_WIDTH-1:0] flags_q,
  output state_t                      state
);
  // Handshake: a result transfers on a rising edge where in_valid && in_ready;
  // the producer must hold its result stable while in_valid is high and in_ready is low.
  wb_class_t                  cls;
  logic                       accept;
  logic                       flags_load;
  logic [REG_IDX_WIDTH-1:0]   hi_addr;
  logic [DATA_WIDTH-1:0]      hi_data;

  assign cls        = get_alu_wb_class(in_oper);
  assign in_ready   = (state == ST_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign flags_load = accept && (cls != CLS_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      hi_addr  <= '0;
      hi_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rf_we <= 1'b0;
          if (accept && (cls == CLS_SINGLE || cls == CLS_PAIR)) begin
            rf_we    <= 1'b1;
            rf_waddr <= in_rd;
            rf_wdata <= in_out_lo;
          end
          // The hi half is parked here and written on the following edge.
          if (accept && cls == CLS_PAIR) begin
            hi_addr <= in_rd + 1'b1;
            hi_data <= in_out_hi;
            state   <= ST_WR_HI;
          end
        end
        ST_WR_HI: begin
          rf_we    <= 1'b1;
          rf_waddr <= hi_addr;
          rf_wdata <= hi_data;
          state    <= ST_IDLE;
        end
        default: begin
          rf_we <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  proc_flags_reg #(
    .WIDTH(PROC_FLAGS_WIDTH)
  ) u_flags (
    .clk  (clk),
    .rst  (rst),
    .load (flags_load),
    .d    (in_flags),
    .q    (flags_q)
  );
endmodule
